// File: rtl/ring_osc_delay_meter.sv
// ============================================================================
// Module   : ring_osc_delay_meter
// Purpose  : Ring-oscillator delay meter. A NAND-gated ring with a selectable
//            odd stage count runs free. Its output is divided by 2^DIV_LOG2
//            in the ring domain, synchronised into clk and edge-counted over
//            a programmable window. The per-stage delay is
//            W*Tclk / (count * 2^DIV_LOG2 * 2 * (2k+1)).
// Ports    : clk, rst_n (async active-low), en, start (rising edge),
//            stage_sel[SEL_W], window_len[WIN_W]  -> inputs
//            busy, done (1-cycle pulse), ovf, count[CNT_W],
//            ring_tap[3] = {prescaler MSB, ring output, NAND output} -> outputs
// Macro    : RODM_CONTINUOUS_EN - a held start level keeps re-measuring
//            window after window instead of stopping after one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

// Ring gating NAND. It is a separate cell so the ring hierarchy can be kept.
module rodm_nand2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
`ifndef SYNTHESIS
    assign #1 o_y = ~(i_a & i_b);
`else
    assign o_y = ~(i_a & i_b);
`endif
endmodule

// Ring inverter cell.
module rodm_inv (
    input  logic i_a,
    output logic o_y
);
`ifndef SYNTHESIS
    assign #1 o_y = ~i_a;
`else
    assign o_y = ~i_a;
`endif
endmodule

// Ring-domain toggle flop. One stage of the ripple prescaler.
module rodm_tff (
    input  logic clk,
    input  logic rst_n,
    output logic o_q
);
    logic r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= ~r_q;
    end
    assign o_q = r_q;
endmodule

module ring_osc_delay_meter #(
    parameter int N_PAIRS  = 7,
    parameter int SEL_W    = 3,
    parameter int DIV_LOG2 = 4,
    parameter int WIN_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [SEL_W-1:0] stage_sel,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       ring_tap
);
    localparam logic [1:0]       c_st_idle    = 2'd0;
    localparam logic [1:0]       c_st_settle  = 2'd1;
    localparam logic [1:0]       c_st_measure = 2'd2;
    localparam logic [1:0]       c_st_done    = 2'd3;
    localparam logic [SEL_W:0]   c_n_pairs    = (SEL_W+1)'(N_PAIRS);
    localparam logic [SEL_W-1:0] c_max_idx    = SEL_W'(N_PAIRS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] c_win_one    = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         r_settle_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WIN_W-1:0]   r_win_reg;
    logic [SEL_W-1:0]   r_stage_idx;
    logic               r_ring_run;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_acc;
    logic               r_acc_ovf;
    logic               r_start_d;
    logic [1:0]         r_sync;
    logic               r_sync_d;
    logic               r_inc;

    logic               w_nand_out;
    logic               w_loop_out;
    logic [N_PAIRS-1:0] w_pair_mid;
    logic [N_PAIRS-1:0] w_pair_out;
    logic [DIV_LOG2-1:0] w_presc;

    // ---------------------------------------------------------------- ring
    rodm_nand2 u_nand (.i_a(r_ring_run), .i_b(w_loop_out), .o_y(w_nand_out));

    generate
        for (genvar gi = 0; gi < N_PAIRS; gi++) begin : g_pair
            if (gi == 0) begin : g_head
                rodm_inv u_inv_a (.i_a(w_nand_out),       .o_y(w_pair_mid[gi]));
            end else begin : g_chain
                rodm_inv u_inv_a (.i_a(w_pair_out[gi-1]), .o_y(w_pair_mid[gi]));
            end
            rodm_inv u_inv_b (.i_a(w_pair_mid[gi]), .o_y(w_pair_out[gi]));
        end
    endgenerate

    // Loop closes at pair k; pairs beyond it just follow along unused.
    assign w_loop_out = w_pair_out[r_stage_idx];

    // ---------------------------------------------------------- prescaler
    // Ripple divider: each later stage toggles on the falling edge of the
    // previous one, so the MSB runs at f_ring / 2^DIV_LOG2.
    generate
        for (genvar gi = 0; gi < DIV_LOG2; gi++) begin : g_presc
            if (gi == 0) begin : g_first
                rodm_tff u_tff (.clk(w_loop_out), .rst_n(rst_n), .o_q(w_presc[gi]));
            end else begin : g_ripple
                logic w_clk_n;
                assign w_clk_n = ~w_presc[gi-1];
                rodm_tff u_tff (.clk(w_clk_n), .rst_n(rst_n), .o_q(w_presc[gi]));
            end
        end
    endgenerate

    assign ring_tap = {w_presc[DIV_LOG2-1], w_loop_out, w_nand_out};

    // ------------------------------------------------- sync + edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b00;
            r_sync_d  <= 1'b0;
            r_inc     <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], w_presc[DIV_LOG2-1]};
            r_sync_d  <= r_sync[1];
            r_inc     <= r_sync[1] & ~r_sync_d;
            r_start_d <= start;
        end
    end

    // ----------------------------------------------------------- control
    logic               w_start_rise;
    logic               w_acc_sat;
    logic [CNT_W-1:0]   w_acc_next;
    logic               w_acc_ovf_next;
    logic [WIN_W-1:0]   w_win_eff;
    logic [SEL_W-1:0]   w_stage_clamped;

    assign w_start_rise    = start & ~r_start_d;
    assign w_acc_sat       = (r_acc == c_cnt_max);
    assign w_acc_next      = (r_inc && !w_acc_sat) ? r_acc + 1'b1 : r_acc;
    assign w_acc_ovf_next  = r_acc_ovf | (r_inc & w_acc_sat);
    assign w_win_eff       = (window_len == '0) ? c_win_one : window_len;
    assign w_stage_clamped = ({1'b0, stage_sel} >= c_n_pairs) ? c_max_idx : stage_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_settle_cnt <= 2'd0;
            r_win_cnt    <= '0;
            r_win_reg    <= '0;
            r_stage_idx  <= '0;
            r_ring_run   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_count      <= '0;
            r_acc        <= '0;
            r_acc_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!en) begin
                r_state    <= c_st_idle;
                r_ring_run <= 1'b0;
                r_busy     <= 1'b0;
                r_acc      <= '0;
                r_acc_ovf  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_start_rise) begin
                            r_stage_idx  <= w_stage_clamped;
                            r_win_reg    <= w_win_eff;
                            r_ovf        <= 1'b0;
                            r_ring_run   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_settle_cnt <= 2'd0;
                            r_acc        <= '0;
                            r_acc_ovf    <= 1'b0;
                            r_state      <= c_st_settle;
                        end
                    end
                    c_st_settle: begin
                        // Lets the ring start and flushes stale synchroniser edges.
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
                        if (r_settle_cnt == 2'd3) begin
                            r_win_cnt <= c_win_one;
                            r_state   <= c_st_measure;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 2'd1;
                        end
                    end
                    c_st_measure: begin
                        r_acc     <= w_acc_next;
                        r_acc_ovf <= w_acc_ovf_next;
                        if (r_win_cnt == r_win_reg) begin
                            r_busy  <= 1'b0;
                            r_state <= c_st_done;
                        end else begin
                            r_win_cnt <= r_win_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // The DONE cycle still takes the last pipelined edge, so
                        // back-to-back windows never drop or double-count an edge.
                        r_count   <= w_acc_next;
                        r_ovf     <= w_acc_ovf_next;
                        r_done    <= 1'b1;
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
`ifdef RODM_CONTINUOUS_EN
                        if (start) begin
                            r_win_cnt <= c_win_one;
                            r_busy    <= 1'b1;
                            r_state   <= c_st_measure;
                        end else begin
                            r_ring_run <= 1'b0;
                            r_state    <= c_st_idle;
                        end
`else
                        r_ring_run <= 1'b0;
                        r_state    <= c_st_idle;
`endif
                    end
                endcase
            end
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign ovf   = r_ovf;
    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ring_osc_delay_meter.sv
// ============================================================================
// Module   : tb_ring_osc_delay_meter
// Purpose  : Scoreboard bench for ring_osc_delay_meter. A full-width DUT and
//            a CNT_W=4 DUT share stimulus; expected counts are pushed when a
//            measurement is launched and popped by a monitor on each done.
//            Expected count = W*20ns / (2*(2k+1)ns * 16), +/-1 for phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ring_osc_delay_meter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  stage_sel = 3'd0;
    logic [15:0] window_len = 16'd0;

    logic        busy, done, ovf;
    logic [15:0] count;
    logic [2:0]  ring_tap;
    logic        s_busy, s_done, s_ovf;
    logic [3:0]  s_count;
    logic [2:0]  s_ring_tap;

    ring_osc_delay_meter u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .stage_sel(stage_sel), .window_len(window_len),
        .busy(busy), .done(done), .ovf(ovf), .count(count), .ring_tap(ring_tap)
    );

    ring_osc_delay_meter #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .stage_sel(stage_sel), .window_len(window_len),
        .busy(s_busy), .done(s_done), .ovf(s_ovf), .count(s_count), .ring_tap(s_ring_tap)
    );

    always #10 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        int s_lo;
        int s_hi;
        bit s_ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check_range(name, act, exp, exp);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_range("count", int'(count), mon_e.lo, mon_e.hi);
                check_eq("ovf", int'(ovf), 0);
                check_eq("small_done", int'(s_done), 1);
                check_range("small_count", int'(s_count), mon_e.s_lo, mon_e.s_hi);
                check_eq("small_ovf", int'(s_ovf), int'(mon_e.s_ovf));
            end
        end
    end

    function automatic exp_t make_exp(input int lo, input int hi);
        exp_t e;
        e.lo    = lo;
        e.hi    = hi;
        e.s_lo  = (lo > 15) ? 15 : lo;
        e.s_hi  = (hi > 15) ? 15 : hi;
        e.s_ovf = (lo > 15);
        return e;
    endfunction

    // Counts posedges until done is seen (sampled 1 ns after each edge).
    task automatic wait_done(input int max_cyc, input bit single, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (single && n == 2) begin
                start = 1'b0;
                check_eq("busy_running", int'(busy), 1);
                check_eq("small_ovf_cleared", int'(s_ovf), 0);
            end
        end while (!done && n < max_cyc);
    endtask

    task automatic run_measure(input logic [2:0] sel, input int win, input int lo, input int hi);
        int n;
        int w_eff;
        w_eff = (win == 0) ? 1 : win;
        sb.push_back(make_exp(lo, hi));
        @(posedge clk);
        #1;
        stage_sel  = sel;
        window_len = 16'(win);
        start      = 1'b1;
        wait_done(w_eff + 50, 1'b1, n);
        check_eq("latency", n, w_eff + 6);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ovf", int'(ovf), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_ring_tap", int'(ring_tap), 3);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(posedge clk);

        // 3-cell ring: 6 ns period, 96 ns prescaled -> 19200/96 = 200
        run_measure(3'd0, 960, 199, 201);
        // 5-cell ring: 10 ns, 160 ns -> 120; small DUT ovf must clear on start
        run_measure(3'd1, 960, 119, 121);
        // stage_sel 7 clamps to 7 pairs: 15 cells, 30 ns, 480 ns -> 40
        run_measure(3'd7, 960, 39, 41);

        // en dropped during MEASURE: no done, count keeps 40
        @(posedge clk);
        #1;
        stage_sel  = 3'd0;
        window_len = 16'd960;
        start      = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (103) @(posedge clk);
        #1;
        check_eq("busy_before_en_drop", int'(busy), 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("busy_after_en_drop", int'(busy), 0);
        repeat (1100) @(posedge clk);
        #1;
        check_range("count_retained", int'(count), 39, 41);
        check_eq("busy_idle_en_low", int'(busy), 0);
        en = 1'b1;
        repeat (3) @(posedge clk);

        // window_len 0 behaves as a 1-cycle window
        run_measure(3'd0, 0, 0, 1);

        // Asynchronous reset in the middle of MEASURE
        @(posedge clk);
        #1;
        stage_sel  = 3'd0;
        window_len = 16'd960;
        start      = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #10;
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_done", int'(done), 0);
        check_eq("mid_rst_ovf", int'(ovf), 0);
        check_eq("mid_rst_count", int'(count), 0);
        check_eq("mid_rst_small_count", int'(s_count), 0);
        check_eq("mid_rst_tap_a", int'(ring_tap), 3);
        #7;
        check_eq("mid_rst_tap_b", int'(ring_tap), 3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_idle", int'(busy), 0);

`ifdef RODM_CONTINUOUS_EN
        // Held start: a done every W+1 cycles, one final window after start falls
        repeat (3) sb.push_back(make_exp(199, 201));
        @(posedge clk);
        #1;
        stage_sel  = 3'd0;
        window_len = 16'd960;
        start      = 1'b1;
        wait_done(1100, 1'b0, n);
        check_eq("cont_first_latency", n, 966);
        wait_done(1100, 1'b0, n);
        check_eq("cont_period", n, 961);
        repeat (100) @(posedge clk);
        #1 start = 1'b0;
        wait_done(1100, 1'b0, n);
        check_eq("cont_final_period", n + 100, 961);
        repeat (5) @(posedge clk);
        #1;
        check_eq("cont_idle", int'(busy), 0);
        repeat (1100) @(posedge clk);
`endif

        repeat (5) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
